diode_sequencer: RTL and testbench

//  Sequences the three-diode blink datapath: drives one of four fixed light patterns, one step per tick.
//  A shared prescaler generates the tick; start/pause and stop buttons control it through an IDLE/RUN/PAUSE FSM.

---
 rtl/diode_sequencer_pkg.sv | 20 ++
 rtl/diode_pattern_gen.sv | 43 ++++
 rtl/rising_edge_detector.sv | 26 ++
 rtl/diode_sequencer.sv | 133 +++++++++++++
 tb/tb_diode_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/diode_sequencer_pkg.sv
// Shared definitions for the diode blink sequencer: FSM states, pattern modes, tick constant.
package diode_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } seq_state_e;

    typedef enum logic [1:0] {
        ModeChase  = 2'b00,
        ModeBounce = 2'b01,
        ModeBlink  = 2'b10,
        ModeBinary = 2'b11
    } mode_e;

    // 250 ms at 50 MHz
    localparam int unsigned TICK_250MS = 32'h00BE_BC20;

endpackage

// File: rtl/diode_pattern_gen.sv
// Combinational pattern lookup: (mode, step) -> diode pattern and sequence length.
module diode_pattern_gen import diode_sequencer_pkg::*; #(
    parameter int unsigned NUM_DIODES = 3
) (
    input  mode_e                 mode,
    input  logic [NUM_DIODES:0]   step,
    output logic [NUM_DIODES-1:0] pattern,
    output logic [NUM_DIODES:0]   period
);

    localparam int unsigned SW = NUM_DIODES + 1;
    localparam int unsigned PW = NUM_DIODES;

    // Decode the current step into a pattern and report the mode's period.
    always_comb begin
        pattern = '0;
        period  = '0;
        unique case (mode)
            ModeChase: begin
                pattern = PW'(1) << step;
                period  = SW'(NUM_DIODES);
            end
            ModeBounce: begin
                // Walk up to the top diode, then back down without repeating the ends.
                if (step < SW'(NUM_DIODES)) begin
                    pattern = PW'(1) << step;
                end else begin
                    pattern = PW'(1) << (SW'(2 * NUM_DIODES - 2) - step);
                end
                period = SW'(2 * NUM_DIODES - 2);
            end
            ModeBlink: begin
                pattern = step[0] ? '0 : '1;
                period  = SW'(2);
            end
            ModeBinary: begin
                pattern = step[NUM_DIODES-1:0];
                period  = SW'(1) << NUM_DIODES;
            end
        endcase
    end

endmodule

// File: rtl/rising_edge_detector.sv
// Rising-edge detector for a raw button level; emits a one-clk pulse per rise.
module rising_edge_detector (
    input  logic clk,
    input  logic async_reset,
    input  logic level,
    output logic pulse
);

    logic sample_q;
    logic hist_q;

    // Sample the raw level and keep one cycle of history.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            sample_q <= 1'b0;
            hist_q   <= 1'b0;
        end else begin
            sample_q <= level;
            hist_q   <= sample_q;
        end
    end

    // Pulse is valid the cycle after the rise is sampled; the consumer acts on the next edge.
    assign pulse = sample_q & ~hist_q;

endmodule

// File: rtl/diode_sequencer.sv
// Diode blink sequencer: shared prescaler tick, IDLE/RUN/PAUSE control, four fixed patterns.
module diode_sequencer import diode_sequencer_pkg::*; #(
    parameter int unsigned NUM_DIODES  = 3,
    parameter int unsigned TICK_CYCLES = TICK_250MS
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic                  btn_start,
    input  logic                  btn_stop,
    input  logic [1:0]            mode_sel,
    output logic [NUM_DIODES-1:0] diodes,
    output logic                  running,
    output logic                  step_tick
);

    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam int unsigned SW = NUM_DIODES + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    logic                  start_pulse;
    logic                  stop_pulse;
    seq_state_e            state_q, state_d;
    logic [PW-1:0]         prescaler_q, prescaler_d;
    logic [SW-1:0]         step_q, step_d;
    mode_e                 mode_q, mode_d;
    logic [NUM_DIODES-1:0] diodes_d;
    logic                  step_tick_d;
    logic [NUM_DIODES-1:0] pattern;
    logic [SW-1:0]         period;
    logic                  tick;
    logic                  wrap;

    rising_edge_detector u_start_edge (
        .clk         (clk),
        .async_reset (async_reset),
        .level       (btn_start),
        .pulse       (start_pulse)
    );

    rising_edge_detector u_stop_edge (
        .clk         (clk),
        .async_reset (async_reset),
        .level       (btn_stop),
        .pulse       (stop_pulse)
    );

    diode_pattern_gen #(
        .NUM_DIODES (NUM_DIODES)
    ) u_pattern_gen (
        .mode    (mode_q),
        .step    (step_q),
        .pattern (pattern),
        .period  (period)
    );

    assign tick = (state_q == StRun) && (prescaler_q == PRE_LAST);
    assign wrap = (step_q == period - SW'(1));

    // Next-state, counters and output drive; stop overrides everything.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        step_d      = step_q;
        mode_d      = mode_q;
        diodes_d    = (state_q == StIdle) ? '0 : pattern;
        step_tick_d = tick & ~stop_pulse;
        if (stop_pulse) begin
            state_d     = StIdle;
            prescaler_d = '0;
            step_d      = '0;
            diodes_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    prescaler_d = '0;
                    step_d      = '0;
                    if (start_pulse) begin
                        state_d = StRun;
                        mode_d  = mode_e'(mode_sel);
                    end
                end
                StRun: begin
                    if (tick) begin
                        prescaler_d = '0;
                        if (wrap) begin
                            step_d = '0;
                            // Mode changes only land on a sequence boundary.
                            mode_d = mode_e'(mode_sel);
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end else begin
                        prescaler_d = prescaler_q + PW'(1);
                    end
                    // A start on a tick cycle still lets the tick complete above.
                    if (start_pulse) begin
                        state_d = StPause;
                    end
                end
                StPause: begin
                    if (start_pulse) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_q     <= StIdle;
            prescaler_q <= '0;
            step_q      <= '0;
            mode_q      <= ModeChase;
            diodes      <= '0;
            running     <= 1'b0;
            step_tick   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            diodes      <= diodes_d;
            running     <= (state_d == StRun);
            step_tick   <= step_tick_d;
        end
    end

endmodule

// File: tb/tb_diode_sequencer.sv
// Randomised self-checking bench for diode_sequencer against a behavioural reference model.
module tb_diode_sequencer;

    localparam int N    = 3;
    localparam int TICK = 4;

    logic         clk;
    logic         async_reset;
    logic         btn_start;
    logic         btn_stop;
    logic [1:0]   mode_sel;
    logic [N-1:0] diodes;
    logic         running;
    logic         step_tick;

    int checks;
    int errors;

    diode_sequencer #(
        .NUM_DIODES  (N),
        .TICK_CYCLES (TICK)
    ) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .btn_start   (btn_start),
        .btn_stop    (btn_stop),
        .mode_sel    (mode_sel),
        .diodes      (diodes),
        .running     (running),
        .step_tick   (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: 0 idle, 1 run, 2 pause.
    int m_state, m_pre, m_step, m_mode;
    int m_diodes, m_running, m_tick;
    int hs1, hs2, hp1, hp2;

    function automatic int seq_period(input int mode);
        case (mode)
            0:       return N;
            1:       return 2 * N - 2;
            2:       return 2;
            default: return 1 << N;
        endcase
    endfunction

    // Expected light pattern written out as explicit sequences.
    function automatic int seq_pattern(input int mode, input int k);
        int chase [3];
        int bounce[4];
        int blink [2];
        chase  = '{1, 2, 4};
        bounce = '{1, 2, 4, 2};
        blink  = '{7, 0};
        case (mode)
            0:       return chase[k % 3];
            1:       return bounce[k % 4];
            2:       return blink[k % 2];
            default: return k % 8;
        endcase
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pre = 0; m_step = 0; m_mode = 0;
        m_diodes = 0; m_running = 0; m_tick = 0;
        hs1 = 0; hs2 = 0; hp1 = 0; hp2 = 0;
    endtask

    // One rising clock edge of the intended behaviour.
    task automatic model_edge();
        int start_p, stop_p, tick, old_mode, old_step;
        if (!async_reset) begin
            model_reset();
            return;
        end
        start_p  = hs1 & ~hs2;
        stop_p   = hp1 & ~hp2;
        tick     = (m_state == 1 && m_pre == TICK - 1) ? 1 : 0;
        old_mode = m_mode;
        old_step = m_step;
        m_tick   = tick & ~stop_p;
        if (stop_p) begin
            m_state = 0; m_pre = 0; m_step = 0; m_diodes = 0;
        end else if (m_state == 0) begin
            m_diodes = 0;
            if (start_p) begin
                m_state = 1;
                m_mode  = mode_sel;
            end
        end else begin
            m_diodes = seq_pattern(old_mode, old_step);
            if (m_state == 1) begin
                if (tick) begin
                    m_pre  = 0;
                    m_step = (old_step + 1) % seq_period(old_mode);
                    if (m_step == 0) m_mode = mode_sel;
                end else begin
                    m_pre++;
                end
                if (start_p) m_state = 2;
            end else if (start_p) begin
                m_state = 1;
            end
        end
        m_running = (m_state == 1) ? 1 : 0;
        hs2 = hs1; hs1 = btn_start;
        hp2 = hp1; hp1 = btn_stop;
    endtask

    task automatic compare_outputs(input string phase);
        check_value({phase, ".diodes"}, 32'(diodes), 32'(m_diodes));
        check_value({phase, ".running"}, 32'(running), 32'(m_running));
        check_value({phase, ".step_tick"}, 32'(step_tick), 32'(m_tick));
    endtask

    task automatic run_cycle(input logic st, input logic sp, input logic [1:0] m, input string phase);
        @(negedge clk);
        btn_start = st;
        btn_stop  = sp;
        mode_sel  = m;
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs(phase);
    endtask

    // Reset glitch between clock edges; outputs must clear without a clock.
    task automatic reset_glitch();
        @(negedge clk);
        #1 async_reset = 1'b0;
        #1;
        model_reset();
        compare_outputs("glitch");
        #1 async_reset = 1'b1;
    endtask

    initial begin
        logic st, sp;
        logic [1:0] m;
        checks = 0;
        errors = 0;
        async_reset = 1'b0;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        mode_sel  = 2'b00;
        model_reset();

        // Reset held low while inputs toggle.
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'($urandom), 1'($urandom), 2'($urandom), "rst_hold");
        end
        @(negedge clk);
        async_reset = 1'b1;

        // Directed chase run with the start level held high.
        run_cycle(1'b0, 1'b0, 2'b00, "chase");
        for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b0, 2'b00, "chase");
        // Mode switched mid-sequence: deferred until the wrap.
        for (int i = 0; i < 30; i++) run_cycle(1'b1, 1'b0, 2'b11, "defer");
        // Pause, hold, resume.
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 2'b11, "pause");
        for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b0, 2'b11, "pause");
        run_cycle(1'b0, 1'b0, 2'b11, "resume");
        for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, 2'b11, "resume");
        // Start and stop rising together: stop wins.
        for (int i = 0; i < 2; i++) run_cycle(1'b0, 1'b0, 2'b01, "both");
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 2'b01, "both");
        reset_glitch();

        // Randomised stretch.
        st = 1'b0; sp = 1'b0; m = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) st = ~st;
            if ($urandom_range(0, 59) == 0) sp = ~sp;
            if ($urandom_range(0, 19) == 0) m = 2'($urandom);
            if ($urandom_range(0, 399) == 0) reset_glitch();
            run_cycle(st, sp, m, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
